// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: GF(2^8) arithmetic, S-boxes, Rcon and FSM states.
// Both the forward and inverse cipher blocks import this package.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEXP = 2'd1,
        DEC  = 2'd2
    } state_t;

    // Entry i is Rcon[i]; index 0 and 11..15 are never used by the schedule.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] i;
        i = gf_inv(x);
        return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the last round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rk_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    logic [7:0]   sb [16];
    logic [127:0] ark;
    logic [127:0] mixed;
    logic [7:0]   a0, a1, a2, a3;

    // Byte index is col*4+row; row r of column c comes from column (c-r) mod 4.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sb[c*4+r] = inv_sbox(state_i[127 - 8*((((c - r + 4) % 4) * 4) + r) -: 8]);
            end
        end
    end

    always_comb begin
        ark   = '0;
        mixed = '0;
        a0    = '0;
        a1    = '0;
        a2    = '0;
        a3    = '0;
        for (int i = 0; i < 16; i++) begin
            ark[127 - 8*i -: 8] = sb[i] ^ rk_i[127 - 8*i -: 8];
        end
        for (int c = 0; c < 4; c++) begin
            a0 = ark[127 - 32*c -: 8];
            a1 = ark[119 - 32*c -: 8];
            a2 = ark[111 - 32*c -: 8];
            a3 = ark[103 - 32*c -: 8];
            mixed[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            mixed[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            mixed[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            mixed[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
    end

    assign state_o = last_i ? ark : mixed;

endmodule

// File: rtl/aes_inv_decipher.sv
// Iterative AES-128 inverse cipher: expands the key forward to rk10, then runs
// rounds 9..0 while stepping the key schedule backwards one round per clock.
module aes_inv_decipher
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] datain,
    input  logic [127:0] key,
    output logic [127:0] dataout,
    output logic         busy,
    output logic         done,
    output logic [1:0]   state_dbg
);

    // Handshake: start is sampled only in IDLE; busy covers the accepting edge
    // through the final round; done is a one-cycle pulse with dataout valid.
    localparam logic [3:0] LAST_CNT = 4'(AES_NR - 1);

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] dout_q, dout_d;
    logic         done_q, done_d;
    logic [7:0]   rcon_cur;
    logic [127:0] rk_fwd, rk_prev, round_out;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0] ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    assign rcon_cur = RCON[cnt_q + 4'd1];
    assign rk_fwd   = key_fwd(rk_q, rcon_cur);
    assign rk_prev  = key_inv(rk_q, rcon_cur);

    // rk_prev equals rk0 when cnt is 0, so the same key path feeds the last round.
    aes_inv_round u_round (
        .state_i (st_q),
        .rk_i    (rk_prev),
        .last_i  (cnt_q == 4'd0),
        .state_o (round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = KEXP;
            KEXP:    if (cnt_q == LAST_CNT) state_d = DEC;
            DEC:     if (cnt_q == 4'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        done      = done_q;
        dataout   = dout_q;
        state_dbg = state_q;
    end

    always_comb begin
        st_d   = st_q;
        rk_d   = rk_q;
        cnt_d  = cnt_q;
        dout_d = dout_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                st_d  = datain;
                rk_d  = key;
                cnt_d = 4'd0;
            end
            KEXP: begin
                rk_d = rk_fwd;
                if (cnt_q == LAST_CNT) st_d = st_q ^ rk_fwd;
                else                   cnt_d = cnt_q + 4'd1;
            end
            DEC: begin
                rk_d  = rk_prev;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    dout_d = round_out;
                    done_d = 1'b1;
                end else begin
                    st_d = round_out;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= '0;
            rk_q   <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            rk_q   <= rk_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            done_q <= done_d;
        end
    end

endmodule

// File: tb/tb_aes_inv_decipher.sv
// Directed bench for aes_inv_decipher using FIPS-197 and SP800-38A vectors.
module tb_aes_inv_decipher;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] datain;
    logic [127:0] key;
    logic [127:0] dataout;
    logic         busy;
    logic         done;
    logic [1:0]   state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    logic [127:0] exp_q[$];

    localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2A  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] P2A  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C2B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C3   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes_inv_decipher dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .datain    (datain),
        .key       (key),
        .dataout   (dataout),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] junk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One block: accept, scramble inputs while busy, wait for done, check result and timing.
    task automatic run_block(input logic [127:0] ct, input logic [127:0] k,
                             input logic [127:0] pt, input string tag);
        int   lat;
        logic seen;
        logic busy_ok;
        @(negedge clk);
        start  = 1'b1;
        datain = ct;
        key    = k;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        datain = junk();
        key    = junk();
        lat     = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && lat < 40) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                busy_ok = busy_ok & busy;
                @(negedge clk);
                lat++;
            end
        end
        check_eq({tag, "_done_seen"}, seen, 1'b1);
        check_eq({tag, "_latency"}, lat, 20);
        check_eq({tag, "_busy_during"}, busy_ok, 1'b1);
        check_eq({tag, "_busy_at_done"}, busy, 1'b0);
        check_eq({tag, "_dataout"}, dataout, pt);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, done, 1'b0);
        check_eq({tag, "_dataout_held"}, dataout, pt);
    endtask

    // Accept a vector-1 block, then assert rst so that edge E<e> performs the reset.
    task automatic abort_at(input int e, input string tag);
        int ndone;
        ndone = 0;
        @(negedge clk);
        start  = 1'b1;
        datain = C1;
        key    = K1;
        @(posedge clk);
        for (int k = 0; k <= e + 25; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (done) ndone++;
            if (k == e - 1) rst = 1'b1;
            if (k == e) begin
                rst = 1'b0;
                check_eq({tag, "_busy"}, busy, 1'b0);
                check_eq({tag, "_done"}, done, 1'b0);
                check_eq({tag, "_dataout"}, dataout, 128'h0);
                check_eq({tag, "_state"}, state_dbg, 2'd0);
            end
        end
        check_eq({tag, "_no_done"}, ndone, 0);
    endtask

    initial begin
        int ndone;
        int first_at;
        int second_at;
        logic [127:0] exp_v;

        rst    = 1'b1;
        start  = 1'b0;
        datain = '0;
        key    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("reset_dataout", dataout, 128'h0);
        check_eq("reset_busy", busy, 1'b0);
        check_eq("reset_done", done, 1'b0);
        check_eq("reset_state", state_dbg, 2'd0);

        run_block(C1, K1, P1, "fips_c1");
        run_block(C2A, K2, P2A, "sp_blk1");
        run_block(C2B, K2, P2B, "fips_b");
        run_block(C3, 128'h0, 128'h0, "zero_key");

        // start held high: second block accepted in the done cycle of the first
        exp_q.push_back(P1);
        exp_q.push_back(P2A);
        ndone     = 0;
        first_at  = -1;
        second_at = -1;
        @(negedge clk);
        start  = 1'b1;
        datain = C1;
        key    = K1;
        @(posedge clk);
        for (int k = 0; k <= 45; k++) begin
            @(negedge clk);
            if (k == 0) begin
                datain = C2A;
                key    = K2;
            end
            if (k == 21) start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) first_at = k;
                if (ndone == 2) second_at = k;
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
                check_eq("b2b_dataout", dataout, exp_v);
            end
        end
        check_eq("b2b_done_count", ndone, 2);
        check_eq("b2b_first_at", first_at, 20);
        check_eq("b2b_second_at", second_at, 41);
        check_eq("b2b_queue_left", exp_q.size(), 0);
        exp_q.delete();

        run_block(C2A, K2, P2A, "pre_abort_kexp");
        abort_at(7, "abort_kexp");
        run_block(C2B, K2, P2B, "pre_abort_dec");
        abort_at(15, "abort_dec");
        run_block(C1, K1, P1, "after_abort");

        // start pulse while busy must be ignored
        ndone    = 0;
        first_at = -1;
        @(negedge clk);
        start  = 1'b1;
        datain = C1;
        key    = K1;
        @(posedge clk);
        for (int k = 0; k <= 45; k++) begin
            @(negedge clk);
            start = (k == 5) ? 1'b1 : 1'b0;
            if (k == 5) begin
                datain = C3;
                key    = 128'h0;
            end
            if (done) begin
                ndone++;
                if (ndone == 1) first_at = k;
                check_eq("ignore_dataout", dataout, P1);
            end
        end
        start = 1'b0;
        check_eq("ignore_done_count", ndone, 1);
        check_eq("ignore_done_at", first_at, 20);
        check_eq("ignore_idle_after", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_inv_decipher.md
# aes_inv_decipher

Iterative AES-128 inverse cipher (FIPS-197 InvCipher): decrypts a 128-bit block produced by `aescipher` under the same 128-bit key. It is the receive-side counterpart of `aescipher` in the same datapath. The block executes one round per clock. Before the rounds start, it expands the cipher key forward to the last round key. During the rounds, it walks the key schedule backwards on the fly. A start/busy/done handshake frames each block.

## Interface
Parameters: none (AES-128 fixed: Nk=4, Nr=10).
- clk  in  1  rising-edge clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to decrypt; sampled only in IDLE.
- datain  in  128  ciphertext. Byte 0 is bits [127:120], column-major per FIPS-197. Sampled on the accepting edge.
- key  in  128  cipher key (round key 0), same byte order. Sampled on the accepting edge.
- dataout  out  128  plaintext; updated only when done is set, then held.
- busy  out  1  high from the accepting edge until the final-round edge.
- done  out  1  one-cycle pulse marking dataout valid.

## Operation
- Reset: state is IDLE; dataout=0, busy=0, done=0. Internal state, round-key and counter registers are cleared.
- **IDLE**: start=1 at an edge does the following:
  - latches datain into the state register and key into the round-key register;
  - sets cnt=0, busy=1, and moves to KEXP.
- **KEXP** (10 edges, cnt 0..9): rk ← forward key step(rk, Rcon[cnt+1]).
  - At cnt=9 the step produces rk10. The same edge also performs state ← state ^ rk10 (initial AddRoundKey), sets cnt ← 9, and moves to DEC.
- **DEC** (10 edges, round r=cnt, 9..0):
  - rk_prev = inverse key step(rk, Rcon[r+1]). The inverse step is computed in this order:
    - w3'=w3^w2;
    - w2'=w2^w1;
    - w1'=w1^w0;
    - w0'=w0^SubWord(RotWord(w3'))^Rcon.
  - r≥1: state ← InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_prev).
  - r=0: dataout ← InvSubBytes(InvShiftRows(state)) ^ rk0 (no InvMixColumns). This edge also sets done=1, busy=0 and moves to IDLE.
  - rk ← rk_prev; cnt ← cnt-1.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 in the MSB of the word. GF(2^8) reduction uses polynomial 0x11b.
- start while busy=1 is ignored; it is not queued. datain and key may change freely after the accepting edge.
- start=1 during the done cycle is accepted, because the FSM is already in IDLE. This gives back-to-back operation with no gap cycle.
- rst during KEXP or DEC aborts the operation:
  - no done pulse is produced;
  - dataout is cleared to 0;
  - the FSM returns to IDLE on that edge.
- rst takes priority over start on the same edge.

## Timing
- The accepting edge is E0. Edges E1..E10 perform key expansion (E10 also applies the rk10 AddRoundKey). Edges E11..E20 perform rounds 9..0.
- busy=1 in the cycles after E0 through E19 (20 cycles). It is 0 after E20.
- done=1 for exactly the one cycle after E20. Latency is 20 cycles from acceptance to valid data.
- Maximum throughput is one block per 21 cycles when start is held high.
- dataout is registered and stable from E20 until the next completion or reset.
- Critical path: InvShiftRows → InvSubBytes → XOR → InvMixColumns, in parallel with the inverse key step. Both fit in one cycle; no pipelining is required.

## Structure
- Shared package `aes_pkg` holds:
  - functions `sbox`, `inv_sbox`, `xtime`, `gmul`;
  - the Rcon constant array;
  - the FSM state typedef {IDLE, KEXP, DEC};
  - constant `AES_NR=10`.
  - `aescipher` is to be migrated onto the same package.
- One combinational sub-module, `aes_inv_round`:
  - inputs: state, round key, last-round flag;
  - output: next state.
- The top module holds the FSM, counter, registers and both key-step functions.

## Test plan
1. FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, datain 69c4e0d86a7b0430d8cdb78070b4c55a → dataout 00112233445566778899aabbccddeeff, done exactly 20 cycles after acceptance.
2. Round trip with `aescipher` vector: key 2b7e151628aed2a6abf7158809cf4f3c, datain 3ad77bb40d7a3660a89ecaf32466ef97 → 6bc1bee22e409f96e93d7e117393172a. Then datain 3925841d02dc09fbdc118597196a0b32 → 3243f6a8885a308d313198a2e0370734.
3. Zero key, datain 66e94bd4ef8a2c3b884cfa59ca342b2e → dataout all zeros. Check busy and done timing, and that done is a single-cycle pulse.
4. start held high across two blocks (vectors 1 then 2): second acceptance occurs in the done cycle; done appears at cycles 20 and 41. Changing datain while busy does not affect the result.
5. Assert rst at E7 (KEXP), and again at E15 (DEC) → no done, dataout=0, busy=0 next cycle. A following vector-1 run produces the correct result.
6. start pulse during busy → ignored: exactly one done, and dataout matches the first block.
